// File: rtl/arith_pkg.sv
// arith_pkg: shared opcodes, FSM encoding and sizing helper for the serial add/sub unit
package arith_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: DIGIT-wide ripple of gate-level full adders, reused every compute cycle
module addsub_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);
  logic [DIGIT:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o  = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: multi-cycle add/subtract, DIGIT bits per clock LSB first, with handshakes and flags
module serial_addsub_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_addsub_unit: WIDTH must be a nonzero multiple of DIGIT");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             zero_q, zero_d, borrow_q, borrow_d;
  logic [IW-1:0]    base;
  logic [DIGIT-1:0] sum;
  logic             cout, c_msb, last;
  assign base = IW'(int'(cnt_q) * DIGIT);
  assign last = cnt_q == LAST;
  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i    (a_q[base +: DIGIT]),
    .b_i    (b_q[base +: DIGIT]),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout),
    .c_msb_o(c_msb)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = (op == OP_SUB) ? ~b : b;
        op_d    = op;
        carry_d = op;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[base +: DIGIT] = sum;
        carry_d = cout;
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          ovf_d    = c_msb ^ cout;
          zero_d   = res_d == '0;
          borrow_d = (op_q == OP_SUB) & ~cout;
          state_d  = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb_serial_addsub_unit: directed checks of the 32/8 unit plus 8-bit bit-serial and single-cycle variants
module tb_serial_addsub_unit;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int vec = 0, errs = 0;

  logic        in_valid = 0, op = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0, result;
  logic        in_ready, out_valid, carry, borrow, overflow, zero;
  logic        bs_in_valid = 0, bs_op = 0, bs_out_ready = 0;
  logic [7:0]  bs_a = 0, bs_b = 0, bs_result;
  logic        bs_in_ready, bs_out_valid, bs_carry, bs_borrow, bs_overflow, bs_zero;
  logic        bp_in_valid = 0, bp_op = 0, bp_out_ready = 0;
  logic [7:0]  bp_a = 0, bp_b = 0, bp_result;
  logic        bp_in_ready, bp_out_valid, bp_carry, bp_borrow, bp_overflow, bp_zero;

  serial_addsub_unit #(.WIDTH(32), .DIGIT(8)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .borrow(borrow), .overflow(overflow), .zero(zero));
  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u8s (
    .clk(clk), .reset(reset), .in_valid(bs_in_valid), .in_ready(bs_in_ready), .op(bs_op), .a(bs_a), .b(bs_b),
    .out_valid(bs_out_valid), .out_ready(bs_out_ready), .result(bs_result), .carry(bs_carry),
    .borrow(bs_borrow), .overflow(bs_overflow), .zero(bs_zero));
  serial_addsub_unit #(.WIDTH(8), .DIGIT(8)) u8p (
    .clk(clk), .reset(reset), .in_valid(bp_in_valid), .in_ready(bp_in_ready), .op(bp_op), .a(bp_a), .b(bp_b),
    .out_valid(bp_out_valid), .out_ready(bp_out_ready), .result(bp_result), .carry(bp_carry),
    .borrow(bp_borrow), .overflow(bp_overflow), .zero(bp_zero));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // got = {result, carry, borrow, overflow, zero}; post = {in_ready after accept, out_valid after handshake}
  task automatic do_op32(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output logic [35:0] got, output int lat, output logic [1:0] post);
    in_valid = 1; op = o; a = x; b = y;
    tick();
    in_valid = 0;
    post[1] = in_ready;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) lat = -1;
    got = {result, carry, borrow, overflow, zero};
    out_ready = 1;
    tick();
    out_ready = 0;
    post[0] = out_valid;
  endtask

  task automatic do_op8s(input logic o, input logic [7:0] x, input logic [7:0] y,
                         output logic [11:0] got, output int lat);
    bs_in_valid = 1; bs_op = o; bs_a = x; bs_b = y;
    tick();
    bs_in_valid = 0;
    lat = 0;
    while (!bs_out_valid && lat < 50) begin tick(); lat++; end
    if (!bs_out_valid) lat = -1;
    got = {bs_result, bs_carry, bs_borrow, bs_overflow, bs_zero};
    bs_out_ready = 1;
    tick();
    bs_out_ready = 0;
  endtask

  task automatic do_op8p(input logic o, input logic [7:0] x, input logic [7:0] y,
                         output logic [11:0] got, output int lat);
    bp_in_valid = 1; bp_op = o; bp_a = x; bp_b = y;
    tick();
    bp_in_valid = 0;
    lat = 0;
    while (!bp_out_valid && lat < 50) begin tick(); lat++; end
    if (!bp_out_valid) lat = -1;
    got = {bp_result, bp_carry, bp_borrow, bp_overflow, bp_zero};
    bp_out_ready = 1;
    tick();
    bp_out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    vec++;
    if ({in_ready, out_valid, result, carry, borrow, overflow, zero} !== {2'b10, 36'h0}) begin
      errs++;
      $display("FAIL reset32 got rdy=%b vld=%b res=%h c=%b b=%b o=%b z=%b want rdy=1 vld=0 all zero",
               in_ready, out_valid, result, carry, borrow, overflow, zero);
    end
    vec++;
    if ({bs_in_ready, bs_out_valid, bs_result, bs_carry, bs_borrow, bs_overflow, bs_zero,
         bp_in_ready, bp_out_valid, bp_result, bp_carry, bp_borrow, bp_overflow, bp_zero} !== {2'b10, 12'h0, 2'b10, 12'h0}) begin
      errs++;
      $display("FAIL reset8 got serial rdy=%b vld=%b res=%h par rdy=%b vld=%b res=%h want rdy=1 vld=0 res=00",
               bs_in_ready, bs_out_valid, bs_result, bp_in_ready, bp_out_valid, bp_result);
    end
  endtask

  task automatic test_add_wrap();
    logic [35:0] g; int l; logic [1:0] p;
    do_op32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, g, l, p);
    vec++;
    if (g !== {32'h0, 4'b1001}) begin errs++; $display("FAIL add_wrap got %h want %h", g, {32'h0, 4'b1001}); end
    vec++;
    if (l !== 4) begin errs++; $display("FAIL add_wrap_latency got %0d want 4", l); end
    vec++;
    if (p !== 2'b00) begin errs++; $display("FAIL add_wrap_handshake got rdy/vld %b want 00", p); end
    do_op32(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, g, l, p);
    vec++;
    if (g !== {32'h2143_6587, 4'b0000}) begin errs++; $display("FAIL add_ripple got %h want %h", g, {32'h2143_6587, 4'b0000}); end
  endtask

  task automatic test_sub();
    logic [35:0] g; int l; logic [1:0] p;
    do_op32(1'b1, 32'h0000_0005, 32'h0000_0007, g, l, p);
    vec++;
    if (g !== {32'hFFFF_FFFE, 4'b0100}) begin errs++; $display("FAIL sub_borrow got %h want %h", g, {32'hFFFF_FFFE, 4'b0100}); end
    vec++;
    if (l !== 4) begin errs++; $display("FAIL sub_latency got %0d want 4", l); end
    do_op32(1'b1, 32'h1234_5678, 32'h1234_5678, g, l, p);
    vec++;
    if (g !== {32'h0, 4'b1001}) begin errs++; $display("FAIL sub_equal got %h want %h", g, {32'h0, 4'b1001}); end
  endtask

  task automatic test_overflow();
    logic [35:0] g; int l; logic [1:0] p;
    do_op32(1'b1, 32'h8000_0000, 32'h0000_0001, g, l, p);
    vec++;
    if (g !== {32'h7FFF_FFFF, 4'b1010}) begin errs++; $display("FAIL sub_ovf got %h want %h", g, {32'h7FFF_FFFF, 4'b1010}); end
    do_op32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, g, l, p);
    vec++;
    if (g !== {32'h8000_0000, 4'b0010}) begin errs++; $display("FAIL add_ovf got %h want %h", g, {32'h8000_0000, 4'b0010}); end
  endtask

  task automatic test_backpressure();
    logic [35:0] g; int l; logic [1:0] p;
    in_valid = 1; op = 0; a = 32'd1; b = 32'd2;
    tick();
    in_valid = 0;
    l = 0;
    while (!out_valid && l < 50) begin tick(); l++; end
    vec++;
    if (l !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", l); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; op = ~i[0]; a = $urandom; b = $urandom;
      tick();
      vec++;
      if ({out_valid, in_ready, result, carry, borrow, overflow, zero} !== {2'b10, 32'd3, 4'b0000}) begin
        errs++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b res=%h flags=%b want vld=1 rdy=0 res=00000003 flags=0000",
                 i, out_valid, in_ready, result, {carry, borrow, overflow, zero});
      end
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    vec++;
    if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL bp_release got vld/rdy %b want 01", {out_valid, in_ready}); end
    do_op32(1'b0, 32'd10, 32'd20, g, l, p);
    vec++;
    if (g !== {32'd30, 4'b0000}) begin errs++; $display("FAIL bp_next got %h want %h", g, {32'd30, 4'b0000}); end
  endtask

  task automatic test_reset_midrun();
    logic [35:0] g; int l; logic [1:0] p;
    in_valid = 1; op = 0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    vec++;
    if ({in_ready, out_valid, result, carry, borrow, overflow, zero} !== {2'b10, 36'h0}) begin
      errs++;
      $display("FAIL reset_midrun got rdy=%b vld=%b res=%h flags=%b want rdy=1 vld=0 res=0 flags=0",
               in_ready, out_valid, result, {carry, borrow, overflow, zero});
    end
    do_op32(1'b0, 32'd3, 32'd4, g, l, p);
    vec++;
    if (g !== {32'd7, 4'b0000} || l !== 4) begin errs++; $display("FAIL after_reset_add got %h lat %0d want %h lat 4", g, l, {32'd7, 4'b0000}); end
    reset = 1; in_valid = 1; op = 0; a = 32'd9; b = 32'd9;
    tick();
    reset = 0; in_valid = 0;
    tick();
    tick();
    vec++;
    if ({in_ready, out_valid, result} !== {2'b10, 32'h0}) begin
      errs++;
      $display("FAIL reset_vs_valid got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0", in_ready, out_valid, result);
    end
  endtask

  task automatic test_widths();
    logic [11:0] g; int l;
    do_op8s(1'b1, 8'h10, 8'h01, g, l);
    vec++;
    if (g !== {8'h0F, 4'b1000}) begin errs++; $display("FAIL serial_sub got %h want %h", g, {8'h0F, 4'b1000}); end
    vec++;
    if (l !== 8) begin errs++; $display("FAIL serial_latency got %0d want 8", l); end
    do_op8p(1'b0, 8'h80, 8'h80, g, l);
    vec++;
    if (g !== {8'h00, 4'b1011}) begin errs++; $display("FAIL single_add got %h want %h", g, {8'h00, 4'b1011}); end
    vec++;
    if (l !== 1) begin errs++; $display("FAIL single_latency got %0d want 1", l); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_midrun();
    test_widths();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
